drc_dvp_rgb565_gray_capture: RTL and testbench
==============================================

Name: drc_dvp_rgb565_gray_capture

Overview:
- Front-end capture stage of the DVP RX controller, directly upstream of the frame downscaler.
- Oversamples the raw DVP bus (pclk, vsync, href, data) in the system clk domain and pairs RGB565 bytes into pixels.
- Converts each pixel to 8-bit grayscale and delivers a valid/ready pixel stream with a frame-last flag.
- A small elastic FIFO absorbs downstream back-pressure, since the sensor cannot be stalled.

Parameters:
- COL_NUM, 640, pixels per line.
- ROW_NUM, 480, lines per frame.
- FIFO_DEPTH, 16, output FIFO entries; power of 2, >=4.
- SYNC_STAGES, 2, synchronizer flops on every DVP input; >=2.

Ports:
- clk  in  1  system clock; must be >=4x dvp_pclk_i frequency.
- rst_n  in  1  asynchronous, active-low reset.
- dvp_pclk_i  in  1  sensor pixel clock, treated as data.
- dvp_vsync_i  in  1  frame sync; high = vertical blanking.
- dvp_href_i  in  1  line valid; high = active bytes.
- dvp_data_i  in  8  sensor byte.
- cap_en_i  in  1  capture enable, sampled at frame start only.
- ovf_clr_i  in  1  clears ovf_o.
- fwd_pxl_data_o  out  8  grayscale pixel.
- fwd_pxl_last_o  out  1  marks pixel COL_NUM*ROW_NUM-1 of a frame.
- fwd_pxl_vld_o  out  1  pixel valid.
- fwd_pxl_rdy_i  in  1  downstream ready.
- ovf_o  out  1  sticky: a pixel was dropped because the FIFO was full.
- frm_err_o  out  1  1-cycle pulse: frame ended with pixel count != COL_NUM*ROW_NUM.

Behaviour:
Reset:
- All outputs 0. FIFO empty. FSM in IDLE. Byte phase 0. Pixel counter 0.

Input sampling:
- pclk, vsync, href and data all pass through SYNC_STAGES flops, keeping them aligned.
- A sample event is one clk in which the synchronized pclk shows a 0->1 edge.
- vsync edges are detected on the synchronized signal.

FSM:
- IDLE: on a vsync falling edge with cap_en_i=1, go to ACTIVE and clear the pixel counter and byte phase. With cap_en_i=0, stay in IDLE.
- ACTIVE: captures bytes.
  - When the counter reaches COL_NUM*ROW_NUM, go to DONE; extra bytes are ignored.
  - On a vsync rising edge before that point, pulse frm_err_o and go to IDLE.
- DONE: on a vsync rising edge, go to IDLE with no error.
- Deasserting cap_en_i mid-frame has no effect until the next frame start.

Byte pairing (ACTIVE only):
- On a sample event with href=1:
  - Phase 0 stores the high byte (R5 = [7:3], G[5:3] = [2:0]).
  - Phase 1 combines with the low byte (G[2:0] = [7:5], B5 = [4:0]) to form a pixel.
  - Phase then toggles.
- A sample event with href=0 forces phase to 0. A dangling odd byte is discarded silently.

Grayscale arithmetic:
- R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
- sum = 77*R8 + 150*G8 + 29*B8, 16-bit unsigned, no overflow (max 65280).
- gray = sum[15:8].
- Gray is registered one clk after the phase-1 event, then written to the FIFO with the last flag.

Last flag:
- The last flag equals (pixel counter == COL_NUM*ROW_NUM-1).
- The pixel counter increments on every formed pixel, whether it was written or dropped.

FIFO:
- Width 9 bits ({last, gray}), depth FIFO_DEPTH.
- fwd_pxl_vld_o = FIFO not empty; data and last come from the FIFO head.
- A pop occurs on vld & rdy.
- Once vld is high, data and last hold stable until the handshake.

Latency:
- fwd_pxl_vld_o rises no more than 4 clk after the clk in which the phase-1 sample event is detected, provided the FIFO was empty.

Overflow:
- A write while the FIFO is full drops the pixel and sets ovf_o.
- A simultaneous pop and write while full is accepted, with no drop.
- ovf_o clears only on ovf_clr_i. If a set and ovf_clr_i coincide, the set wins.

Reset mid-frame:
- Asserting reset mid-frame returns to IDLE and empties the FIFO.
- Capture resumes only at the next vsync falling edge.

Test Plan:
- One pixel of each colour with COL_NUM=2, ROW_NUM=2, rdy=1:
  - 0xFFFF -> 255.
  - 0x0000 -> 0.
  - 0xF800 -> 76.
  - 0x07E0 -> 149.
  - 0x001F -> 28.
- Full 2x2 frame of 0xFFFF, rdy=1 -> exactly 4 outputs of 255; last=1 only on the 4th; frm_err_o=0; FSM returns to IDLE at the vsync rising edge.
- Frame cut after 3 pixels (vsync rises early) -> 3 outputs, none with last; one frm_err_o pulse.
- rdy=0 throughout an 8x4 frame with FIFO_DEPTH=16:
  - First 16 pixels are kept and ovf_o=1.
  - After rdy=1, 16 pixels drain in order.
  - ovf_clr_i clears ovf_o.
- Odd byte count on a line (href drops after 3 bytes) -> 1 pixel output; the next line pairs correctly from its first byte.
- cap_en_i=0 at a vsync falling edge -> no output for that frame. cap_en_i=1 at the following falling edge -> next frame captured normally.

Source files
------------

// File: rtl/drc_dvp_rgb565_gray_capture.sv
// DVP RGB565 capture front-end: oversamples the raw sensor bus in the clk
// domain, pairs bytes into RGB565 pixels, converts them to 8-bit grayscale and
// buffers them in a small FIFO feeding a valid/ready stream with frame-last.
//
// Ports:
//   clk, rst_n           system clock (>=4x dvp_pclk_i), async active-low reset
//   dvp_pclk_i           sensor pixel clock, sampled as data
//   dvp_vsync_i          frame sync, high during vertical blanking
//   dvp_href_i           line valid, high while bytes are active
//   dvp_data_i[7:0]      sensor byte
//   cap_en_i             capture enable, looked at only at frame start
//   ovf_clr_i            clears the sticky overflow flag
//   fwd_pxl_data_o[7:0]  grayscale pixel at FIFO head
//   fwd_pxl_last_o       last pixel of the frame
//   fwd_pxl_vld_o        FIFO not empty
//   fwd_pxl_rdy_i        downstream ready
//   ovf_o                sticky: a pixel was dropped on a full FIFO
//   frm_err_o            1-cycle pulse: frame ended short
module drc_dvp_rgb565_gray_capture #(
  parameter int unsigned COL_NUM     = 640,
  parameter int unsigned ROW_NUM     = 480,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dvp_pclk_i,
  input  logic       dvp_vsync_i,
  input  logic       dvp_href_i,
  input  logic [7:0] dvp_data_i,
  input  logic       cap_en_i,
  input  logic       ovf_clr_i,
  output logic [7:0] fwd_pxl_data_o,
  output logic       fwd_pxl_last_o,
  output logic       fwd_pxl_vld_o,
  input  logic       fwd_pxl_rdy_i,
  output logic       ovf_o,
  output logic       frm_err_o
);

  localparam int unsigned PIX_NUM = COL_NUM * ROW_NUM;
  localparam int unsigned CNT_W   = $clog2(PIX_NUM + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW     = AW + 1;
  localparam int unsigned SW      = 11;
  localparam int unsigned FW      = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Input synchronizer: all DVP lines travel together so they stay aligned.
  logic [SW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {dvp_pclk_i, dvp_vsync_i, dvp_href_i, dvp_data_i};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic       pclk_s, vsync_s, href_s;
  logic [7:0] data_s;
  assign {pclk_s, vsync_s, href_s, data_s} = sync_q[SYNC_STAGES-1];

  // Edge detection on the synchronized pclk and vsync.
  logic pclk_prev_q, vsync_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      pclk_prev_q  <= pclk_s;
      vsync_prev_q <= vsync_s;
    end
  end

  logic sample_c, vs_rise_c, vs_fall_c;
  assign sample_c  = pclk_s & ~pclk_prev_q;
  assign vs_rise_c = vsync_s & ~vsync_prev_q;
  assign vs_fall_c = ~vsync_s & vsync_prev_q;

  // Frame FSM.
  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic             start_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_full_c;

  assign cnt_full_c = (cnt_q == CNT_W'(PIX_NUM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vs_fall_c && cap_en_i) begin
          state_d = ST_ACTIVE;
          start_c = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A frame that completes exactly as vsync rises is not an error.
        if (vs_rise_c) begin
          state_d = ST_IDLE;
          err_d   = ~cnt_full_c;
        end else if (cnt_full_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (vs_rise_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte pairing and pixel counting.
  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;
  logic       form_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    form_c  = 1'b0;
    if (start_c) begin
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (state_q == ST_ACTIVE && sample_c) begin
      if (!href_s) begin
        phase_d = 1'b0;
      end else if (!cnt_full_c) begin
        if (!phase_q) begin
          hi_d    = data_s;
          phase_d = 1'b1;
        end else begin
          form_c  = 1'b1;
          phase_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Grayscale: expand to 8 bits per channel, weight 77/150/29, keep the top byte.
  logic [7:0] r8_c, g8_c, b8_c, gray_c;
  logic [5:0] g6_c;
  logic       pix_last_c;

  assign g6_c   = {hi_q[2:0], data_s[7:5]};
  assign r8_c   = {hi_q[7:3], hi_q[7:5]};
  assign g8_c   = {g6_c, g6_c[5:4]};
  assign b8_c   = {data_s[4:0], data_s[4:2]};
  assign gray_c = 8'((16'(r8_c) * 16'd77 + 16'(g8_c) * 16'd150
                    + 16'(b8_c) * 16'd29) >> 8);
  assign pix_last_c = (cnt_q == CNT_W'(PIX_NUM - 1));

  logic       wr_q;
  logic [7:0] gray_q;
  logic       glast_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      gray_q  <= '0;
      glast_q <= 1'b0;
    end else begin
      wr_q <= form_c;
      if (form_c) begin
        gray_q  <= gray_c;
        glast_q <= pix_last_c;
      end
    end
  end

  // Output FIFO; a pop in the same cycle frees room for a write when full.
  logic [FW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           vld_q, ovf_q, ovf_d;
  logic           pop_c, full_c, push_c, drop_c;

  assign pop_c  = vld_q & fwd_pxl_rdy_i;
  assign full_c = (fcnt_q == FCW'(FIFO_DEPTH));
  assign push_c = wr_q & (~full_c | pop_c);
  assign drop_c = wr_q & full_c & ~pop_c;

  always_comb begin
    fcnt_d = fcnt_q;
    if (push_c && !pop_c)      fcnt_d = fcnt_q + FCW'(1);
    else if (!push_c && pop_c) fcnt_d = fcnt_q - FCW'(1);
    ovf_d = ovf_q;
    if (drop_c)         ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= {glast_q, gray_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      fcnt_q <= fcnt_d;
      vld_q  <= (fcnt_d != '0);
      ovf_q  <= ovf_d;
    end
  end

  assign fwd_pxl_data_o = mem_q[rd_ptr_q][7:0];
  assign fwd_pxl_last_o = mem_q[rd_ptr_q][8];
  assign fwd_pxl_vld_o  = vld_q;
  assign ovf_o          = ovf_q;
  assign frm_err_o      = err_q;

endmodule

// File: tb/tb_drc_dvp_rgb565_gray_capture.sv
// Directed bench: a 2x2 instance for colour, framing, odd-byte and enable
// cases, and an 8x4 instance for FIFO overflow and drain.
module tb_drc_dvp_rgb565_gray_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dvp_pclk, dvp_vsync, dvp_href;
  logic [7:0] dvp_data;
  logic       cap_en_a, cap_en_b, ovf_clr_a, ovf_clr_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       last_a, last_b, vld_a, vld_b, ovf_a, ovf_b, err_a, err_b;

  always #5 clk = ~clk;

  drc_dvp_rgb565_gray_capture #(.COL_NUM(2), .ROW_NUM(2), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .dvp_pclk_i(dvp_pclk), .dvp_vsync_i(dvp_vsync),
    .dvp_href_i(dvp_href), .dvp_data_i(dvp_data), .cap_en_i(cap_en_a), .ovf_clr_i(ovf_clr_a),
    .fwd_pxl_data_o(data_a), .fwd_pxl_last_o(last_a), .fwd_pxl_vld_o(vld_a),
    .fwd_pxl_rdy_i(rdy_a), .ovf_o(ovf_a), .frm_err_o(err_a));

  drc_dvp_rgb565_gray_capture #(.COL_NUM(8), .ROW_NUM(4), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .dvp_pclk_i(dvp_pclk), .dvp_vsync_i(dvp_vsync),
    .dvp_href_i(dvp_href), .dvp_data_i(dvp_data), .cap_en_i(cap_en_b), .ovf_clr_i(ovf_clr_b),
    .fwd_pxl_data_o(data_b), .fwd_pxl_last_o(last_b), .fwd_pxl_vld_o(vld_b),
    .fwd_pxl_rdy_i(rdy_b), .ovf_o(ovf_b), .frm_err_o(err_b));

  int n_vec = 0;
  int n_err = 0;
  int err_cnt_a = 0;
  int err_cnt_b = 0;
  logic [8:0] q_a [$];
  logic [8:0] q_b [$];

  logic [15:0] pal  [5] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
  logic [7:0]  gpal [5] = '{8'd255, 8'd0, 8'd76, 8'd149, 8'd28};

  // Output monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n && vld_a && rdy_a) q_a.push_back({last_a, data_a});
    if (rst_n && vld_b && rdy_b) q_b.push_back({last_b, data_b});
    if (err_a) err_cnt_a++;
    if (err_b) err_cnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic h);
    dvp_data = b;
    dvp_href = h;
    dvp_pclk = 1'b0;
    repeat (3) tick();
    dvp_pclk = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic line_gap();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
  endtask

  task automatic frame_start();
    dvp_vsync = 1'b1;
    line_gap();
    dvp_vsync = 1'b0;
    line_gap();
  endtask

  task automatic frame_end();
    send_byte(8'h00, 1'b0);
    dvp_vsync = 1'b1;
    line_gap();
    repeat (30) tick();
  endtask

  task automatic exp_pop(input string tag, input bit sel_b, input logic [7:0] g, input logic l);
    logic [8:0] e;
    int sz;
    sz = sel_b ? q_b.size() : q_a.size();
    if (sz == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      if (sel_b) e = q_b.pop_front();
      else       e = q_a.pop_front();
      chk({tag, "_gray"}, 32'(e[7:0]), 32'(g));
      chk({tag, "_last"}, 32'(e[8]), 32'(l));
    end
  endtask

  initial begin
    int e0;
    rst_n = 1'b0;
    dvp_pclk = 1'b0; dvp_vsync = 1'b0; dvp_href = 1'b0; dvp_data = 8'h00;
    cap_en_a = 1'b1; cap_en_b = 1'b0; ovf_clr_a = 1'b0; ovf_clr_b = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) tick();
    chk("rst_vld", 32'(vld_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_last", 32'(last_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_vld_b", 32'(vld_b), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Colour frame: white, black, red, green.
    e0 = err_cnt_a;
    frame_start();
    send_pixel(16'hFFFF); send_pixel(16'h0000); line_gap();
    send_pixel(16'hF800); send_pixel(16'h07E0);
    frame_end();
    chk("col_n", 32'(q_a.size()), 32'd4);
    exp_pop("col_white", 1'b0, 8'd255, 1'b0);
    exp_pop("col_black", 1'b0, 8'd0,   1'b0);
    exp_pop("col_red",   1'b0, 8'd76,  1'b0);
    exp_pop("col_green", 1'b0, 8'd149, 1'b1);
    chk("col_err", 32'(err_cnt_a - e0), 32'd0);

    // Full white frame.
    e0 = err_cnt_a;
    frame_start();
    send_pixel(16'hFFFF); send_pixel(16'hFFFF); line_gap();
    send_pixel(16'hFFFF); send_pixel(16'hFFFF);
    frame_end();
    chk("full_n", 32'(q_a.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      exp_pop($sformatf("full_%0d", i), 1'b0, 8'd255, (i == 3));
    chk("full_err", 32'(err_cnt_a - e0), 32'd0);

    // Frame cut after 3 pixels, includes blue.
    e0 = err_cnt_a;
    frame_start();
    send_pixel(16'h001F); send_pixel(16'hFFFF); line_gap();
    send_pixel(16'h0000);
    frame_end();
    chk("cut_n", 32'(q_a.size()), 32'd3);
    exp_pop("cut_blue",  1'b0, 8'd28,  1'b0);
    exp_pop("cut_white", 1'b0, 8'd255, 1'b0);
    exp_pop("cut_black", 1'b0, 8'd0,   1'b0);
    chk("cut_err", 32'(err_cnt_a - e0), 32'd1);

    // Odd byte count on the first line; later lines pair from their first byte.
    e0 = err_cnt_a;
    frame_start();
    send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h07, 1'b1);
    line_gap();
    send_pixel(16'h07E0); send_pixel(16'h001F); line_gap();
    send_pixel(16'hFFFF);
    frame_end();
    chk("odd_n", 32'(q_a.size()), 32'd4);
    exp_pop("odd_red",   1'b0, 8'd76,  1'b0);
    exp_pop("odd_green", 1'b0, 8'd149, 1'b0);
    exp_pop("odd_blue",  1'b0, 8'd28,  1'b0);
    exp_pop("odd_white", 1'b0, 8'd255, 1'b1);
    chk("odd_err", 32'(err_cnt_a - e0), 32'd0);

    // Capture disabled at frame start, then enabled; mid-frame deassert ignored.
    e0 = err_cnt_a;
    cap_en_a = 1'b0;
    frame_start();
    for (int i = 0; i < 4; i++) send_pixel(16'hFFFF);
    frame_end();
    chk("dis_n", 32'(q_a.size()), 32'd0);
    chk("dis_err", 32'(err_cnt_a - e0), 32'd0);
    cap_en_a = 1'b1;
    frame_start();
    cap_en_a = 1'b0;
    send_pixel(16'h0000); send_pixel(16'h0000); line_gap();
    send_pixel(16'h0000); send_pixel(16'h0000);
    frame_end();
    chk("en_n", 32'(q_a.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      exp_pop($sformatf("en_%0d", i), 1'b0, 8'd0, (i == 3));

    // Overflow on the 8x4 instance with downstream stalled.
    e0 = err_cnt_b;
    cap_en_b = 1'b1;
    rdy_b = 1'b0;
    frame_start();
    cap_en_b = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) send_pixel(pal[(r * 8 + c) % 5]);
      line_gap();
    end
    frame_end();
    chk("ovf_set", 32'(ovf_b), 32'd1);
    chk("ovf_vld", 32'(vld_b), 32'd1);
    chk("ovf_err", 32'(err_cnt_b - e0), 32'd0);
    rdy_b = 1'b1;
    repeat (40) tick();
    chk("drain_n", 32'(q_b.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      exp_pop($sformatf("drain_%0d", i), 1'b1, gpal[i % 5], 1'b0);
    chk("drain_vld", 32'(vld_b), 32'd0);
    chk("ovf_hold", 32'(ovf_b), 32'd1);
    ovf_clr_b = 1'b1;
    tick();
    ovf_clr_b = 1'b0;
    tick();
    chk("ovf_clr", 32'(ovf_b), 32'd0);

    // Reset mid-frame: no capture until the next vsync falling edge.
    cap_en_a = 1'b1;
    frame_start();
    send_pixel(16'hFFFF);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("mrst_vld", 32'(vld_a), 32'd0);
    rst_n = 1'b1;
    q_a.delete();
    send_pixel(16'hFFFF); send_pixel(16'hF800);
    frame_end();
    chk("mrst_n", 32'(q_a.size()), 32'd0);
    frame_start();
    send_pixel(16'hF800); send_pixel(16'h07E0); line_gap();
    send_pixel(16'h001F); send_pixel(16'hFFFF);
    frame_end();
    chk("resume_n", 32'(q_a.size()), 32'd4);
    exp_pop("resume_0", 1'b0, 8'd76,  1'b0);
    exp_pop("resume_1", 1'b0, 8'd149, 1'b0);
    exp_pop("resume_2", 1'b0, 8'd28,  1'b0);
    exp_pop("resume_3", 1'b0, 8'd255, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
